// File: rtl/psk_mod_gen.sv
`default_nettype none
// ============================================================================
// psk_mod_gen : PRBS-15 driven BPSK/QPSK/8PSK Gray-mapped carrier modulator
// Revision    : 1.0
// ============================================================================
module psk_mod_gen #(
   parameter int          OUT_W        = 9,
   parameter int          PH_W         = 6,
   parameter int          CARRIER_STEP = 1,
   parameter int          SYM_LEN      = 64,
   parameter logic [14:0] SEED         = 15'h0001
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic                    load_seed,
   input  logic [14:0]             seed,
   output logic signed [OUT_W-1:0] sample,
   output logic                    sample_valid,
   output logic                    sym_strobe,
   output logic [2:0]              sym_bits,
   output logic                    i_bit,
   output logic                    q_bit
);

   localparam int              LUT_N   = 1 << PH_W;
   localparam int              SC_W    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
   localparam real             AMP     = real'((1 << (OUT_W - 1)) - 1);
   localparam real             TWO_PI  = 6.283185307179586;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYM_LEN - 1);
   localparam logic [PH_W-1:0] PH_STEP = PH_W'(CARRIER_STEP);
   localparam logic [1:0]      M_BPSK  = 2'b00;
   localparam logic [1:0]      M_QPSK  = 2'b01;
   localparam logic [1:0]      M_8PSK  = 2'b10;

   // Sine table, rounded half away from zero, built at elaboration
   logic signed [OUT_W-1:0] lut [LUT_N];
   for (genvar k = 0; k < LUT_N; k++) begin : g_lut
      localparam real    VAL  = AMP * $sin(TWO_PI * real'(k) / real'(LUT_N));
      localparam integer IVAL = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
      assign lut[k] = OUT_W'(IVAL);
   end

   logic [14:0]     lfsr;
   logic [PH_W-1:0] acc;
   logic [SC_W-1:0] sc;
   logic [1:0]      act_mode;
   logic [PH_W-1:0] offset;

   logic [14:0]     step1, step2, step3, draw_lfsr;
   logic [1:0]      new_mode, cur_mode;
   logic [2:0]      draw_bits, draw_idx, cur_bits;
   logic [PH_W-1:0] new_off, cur_off, addr;
   logic            start, cur_i, cur_q;

   always_comb begin
      step1     = {lfsr[13:0],  lfsr[14]  ^ lfsr[13]};
      step2     = {step1[13:0], step1[14] ^ step1[13]};
      step3     = {step2[13:0], step2[14] ^ step2[13]};
      new_mode  = (mode == 2'b11) ? M_QPSK : mode;
      draw_bits = {1'b0, lfsr[14:13]};
      draw_lfsr = step2;
      draw_idx  = {lfsr[14], lfsr[14] ^ lfsr[13], 1'b1};
      // Bits drawn are lfsr[14], lfsr[13], lfsr[12] in draw order; the
      // index is the Gray-decoded constellation point in eighths of a turn.
      case (new_mode)
         M_BPSK: begin
            draw_bits = {2'b00, lfsr[14]};
            draw_lfsr = step1;
            draw_idx  = {lfsr[14], 2'b00};
         end
         M_8PSK: begin
            draw_bits = lfsr[14:12];
            draw_lfsr = step3;
            draw_idx  = {lfsr[14], lfsr[14] ^ lfsr[13], lfsr[14] ^ lfsr[13] ^ lfsr[12]};
         end
         default: begin
            draw_bits = {1'b0, lfsr[14:13]};
            draw_lfsr = step2;
            draw_idx  = {lfsr[14], lfsr[14] ^ lfsr[13], 1'b1};
         end
      endcase
      new_off  = PH_W'(draw_idx) << (PH_W - 3);
      start    = en && (sc == '0);
      cur_mode = start ? new_mode  : act_mode;
      cur_bits = start ? draw_bits : sym_bits;
      cur_off  = start ? new_off   : offset;
      addr     = acc + cur_off;
      cur_i    = cur_bits[1];
      cur_q    = 1'b0;
      case (cur_mode)
         M_BPSK:  cur_i = cur_bits[0];
         M_8PSK:  cur_i = cur_bits[2];
         default: begin
            cur_i = cur_bits[1];
            cur_q = cur_bits[0];
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr         <= SEED;
         acc          <= '0;
         sc           <= '0;
         act_mode     <= M_BPSK;
         offset       <= '0;
         sample       <= '0;
         sample_valid <= 1'b0;
         sym_strobe   <= 1'b0;
         sym_bits     <= '0;
         i_bit        <= 1'b0;
         q_bit        <= 1'b0;
      end else begin
         sample_valid <= en;
         sym_strobe   <= start;
         // A reload wins over the draw, but the draw still uses the old state
         if (load_seed)
            lfsr <= (seed == '0) ? 15'h0001 : seed;
         else if (start)
            lfsr <= draw_lfsr;
         if (en) begin
            acc      <= acc + PH_STEP;
            sc       <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
            act_mode <= cur_mode;
            offset   <= cur_off;
            sample   <= lut[addr];
            sym_bits <= cur_bits;
            i_bit    <= cur_i;
            q_bit    <= cur_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/psk_mod_gen.md
Name: psk_mod_gen

Overview:
- Parametrised successor to the fixed QPSK generate/modulate pair.
- Contains a PRBS-15 bit source, a mode-selectable BPSK/QPSK/8PSK Gray mapper and a carrier phase accumulator.
- Produces signed carrier samples from a sine LUT.
- Feeds the DAC-facing sample bus and supplies symbol reference bits to a downstream demodulator/checker.

Parameters:
- OUT_W, 9, sample width (signed two's complement); amplitude A = 2^(OUT_W-1)-1.
- PH_W, 6, phase accumulator and LUT address width; LUT has 2^PH_W entries.
- CARRIER_STEP, 1, phase increment per enabled sample (1..2^PH_W-1).
- SYM_LEN, 64, enabled samples per symbol (2..4096).
- SEED, 15'h0001, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; all state advances only when high.
- mode  in  2  00 BPSK, 01 QPSK, 10 8PSK, 11 reserved (treated as QPSK).
- load_seed  in  1  synchronous LFSR reload pulse.
- seed  in  15  value loaded on load_seed.
- sample  out  OUT_W  modulated carrier sample.
- sample_valid  out  1  registered copy of en.
- sym_strobe  out  1  high with the first sample of each symbol.
- sym_bits  out  3  bits of current symbol, right-aligned, first-drawn bit is MSB.
- i_bit  out  1  QPSK: sym_bits[1]; BPSK: sym_bits[0]; 8PSK: sym_bits[2].
- q_bit  out  1  QPSK: sym_bits[0]; BPSK/8PSK: 0.

Behaviour:
- Reset (async, rst_n=0): LFSR=SEED, phase acc=0, sample counter sc=0, active mode=BPSK, symbol offset=0. Outputs sample, sample_valid, sym_strobe, sym_bits, i_bit, q_bit all 0.
- LFSR: Fibonacci x^15+x^14+1 on state s[14:0]; output bit = s[14]; one step: s <= {s[13:0], s[14]^s[13]}.
- Symbol start: occurs on an en cycle with sc==0.
  - mode is sampled here and becomes the active mode; mode changes mid-symbol take effect only at the next symbol start.
  - k bits are drawn (BPSK 1, QPSK 2, 8PSK 3) by unrolling k LFSR steps in one cycle.
  - Symbol phase offset (in LUT steps of 2^PH_W/8, shown here for PH_W=6):
    - BPSK: 0→0, 1→32.
    - QPSK Gray: 00→8, 01→24, 11→40, 10→56.
    - 8PSK Gray: 000→0, 001→8, 011→16, 010→24, 110→32, 111→40, 101→48, 100→56.
- sc increments on each en cycle and wraps SYM_LEN-1→0.
- Phase acc adds CARRIER_STEP each en cycle, mod 2^PH_W. It is not reset at symbol boundaries.
- Sample generation: addr = (acc + offset) mod 2^PH_W, using the pre-increment acc and the offset of the symbol current in that cycle, including a symbol starting that cycle. LUT[k] = round(A*sin(2*pi*k/2^PH_W)), computed at elaboration.
- Latency: sample, sample_valid, sym_strobe, sym_bits, i_bit, q_bit are registered, valid 1 cycle after the en cycle that produced them.
- en=0: all state and sample/sym_bits hold; sample_valid=0 and sym_strobe=0 next cycle.
- load_seed: s <= seed, or 15'h0001 if seed==0. It has priority over an LFSR advance in the same cycle; the symbol drawn that cycle uses the pre-load state. sc, acc and offset are unaffected.
- rst_n asserted mid-symbol: immediate return to reset values. The first en after release starts a new symbol drawn from SEED.

Test Plan:
- Reset/first symbol (defaults, BPSK, seed 1): release reset, hold en=1. First output: sym_strobe=1, sym_bits=0, sample=LUT[0]=0. At count 16 (acc=16): sample=+255. sym_strobe repeats every 64 valid samples.
- BPSK polarity: load_seed 15'h4000 while en=0, then en=1. First bit=1, offset 32; sample at acc=16 is -255, at acc=48 is +255.
- QPSK Gray map: load seed so the first two bits are 11. Expect sym_bits=3'b011, i_bit=1, q_bit=1. Sample at acc=0 is round(255*sin(225°))=-180. The LFSR advances exactly 2 steps per symbol.
- Mode change mid-symbol: switch BPSK→8PSK at sample 10. Symbol 1 stays BPSK for all 64 samples; symbol 2 draws 3 bits. A bench LFSR model matches sym_bits for 1000 symbols.
- en gaps and seed edge: random en duty 30%. Outputs hold during en=0, with sample_valid/sym_strobe low. load_seed with seed=0 yields state 15'h0001. LFSR period is 32767 steps.
- Async reset mid-symbol: assert rst_n at sample 37 without a clock edge. Outputs go to 0 immediately; after release, the sequence is identical to the first scenario.
